// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// | Module      : cordic_pkg                                                 |
// | Description : Shared constants for the vectoring-mode CORDIC: arctangent |
// |               table, quarter-turn pre-rotation angle, FSM states and     |
// |               gain-compensation shift amounts.                           |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
package cordic_pkg;

  // Angle constants are Fixpoint(13:10), radians.
  localparam int ATAN_W = 13;

  // atan(2^-i) for i = 0..10
  localparam logic signed [ATAN_W-1:0] ATAN [0:10] = '{
    13'sd804, 13'sd475, 13'sd251, 13'sd127, 13'sd64, 13'sd32,
    13'sd16,  13'sd8,   13'sd4,   13'sd2,   13'sd1
  };

  // pi/2, applied by the quadrant pre-rotation
  localparam logic signed [ATAN_W-1:0] PI_2 = 13'sd1608;

  // 1/K ~ 0.6074 realised as x/2 + x/8 - x/64 - x/512
  localparam int GAIN_SH0 = 1;
  localparam int GAIN_SH1 = 3;
  localparam int GAIN_SH2 = 6;
  localparam int GAIN_SH3 = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_GAIN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Table lookup that returns zero beyond the end of the table
  function automatic logic signed [ATAN_W-1:0] atan_lut(input logic [3:0] i);
    atan_lut = '0;
    if (i <= 4'd10) atan_lut = ATAN[i];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_vectoring_if.sv
`default_nettype none
// ============================================================================
// | Module      : cordic_vectoring_if                                        |
// | Description : Valid/ready input vector and output result channel of the  |
// |               vectoring CORDIC.                                          |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
interface cordic_vectoring_if #(
  parameter int W  = 12,
  parameter int AW = W + 1,
  parameter int IW = W + 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  x_in;
  logic signed [W-1:0]  y_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] angle_out;
  logic signed [IW-1:0] mag_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, angle_out, mag_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, angle_out, mag_out
  );
endinterface
`default_nettype wire

// File: rtl/cordic_vec_step.sv
`default_nettype none
// ============================================================================
// | Module      : cordic_vec_step                                            |
// | Description : One combinational vectoring micro-rotation. Rotates toward |
// |               y = 0 by atan(2^-i) and accumulates the angle in z.        |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module cordic_vec_step
  import cordic_pkg::*;
#(
  parameter int IW = 14,
  parameter int AW = 13,
  parameter int CW = 4
) (
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic signed [AW-1:0] z,
  input  logic        [CW-1:0] i,
  output logic signed [IW-1:0] x_next,
  output logic signed [IW-1:0] y_next,
  output logic signed [AW-1:0] z_next
);

  logic signed [IW-1:0] w_xs;
  logic signed [IW-1:0] w_ys;
  logic signed [AW-1:0] w_atan;

  assign w_xs   = x >>> i;
  assign w_ys   = y >>> i;
  assign w_atan = AW'(atan_lut(4'(i)));

  // Rotate against the sign of y; every term uses the pre-step values
  always_comb begin
    x_next = x;
    y_next = y;
    z_next = z;
    if (!y[IW-1]) begin
      x_next = x + w_ys;
      y_next = y - w_xs;
      z_next = z + w_atan;
    end else begin
      x_next = x - w_ys;
      y_next = y + w_xs;
      z_next = z - w_atan;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_vectoring.sv
`default_nettype none
// ============================================================================
// | Module      : cordic_vectoring                                           |
// | Description : Iterative vectoring-mode CORDIC. Returns atan2(y,x) and    |
// |               the magnitude of a Fixpoint(W:W-2) vector, one micro-      |
// |               rotation per enabled clock through a shared step unit.     |
// |               Optional macro CORDIC_VEC_GAIN_COMP_EN adds a GAIN cycle   |
// |               that scales the magnitude by ~1/1.6468.                    |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int W  = 12,
  parameter int N  = 11,
  parameter int AW = W + 1,
  parameter int IW = W + 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ce,
  cordic_vectoring_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [AW-1:0] r_z;
  logic        [CW-1:0] r_count;
  logic                 r_zero;
  logic signed [AW-1:0] r_angle;
  logic signed [IW-1:0] r_mag;
  logic signed [IW-1:0] w_x_in;
  logic signed [IW-1:0] w_y_in;
  logic signed [IW-1:0] w_x_next;
  logic signed [IW-1:0] w_y_next;
  logic signed [AW-1:0] w_z_next;
  logic                 w_accept;
  logic                 w_last;

  // Widen before any negation so that -(-2.0) is representable
  assign w_x_in   = IW'(bus.x_in);
  assign w_y_in   = IW'(bus.y_in);
  assign w_accept = ce & bus.in_valid & (r_state == ST_IDLE);
  assign w_last   = (r_count == CW'(N - 1));

  cordic_vec_step #(
    .IW (IW),
    .AW (AW),
    .CW (CW)
  ) u_step (
    .x      (r_x),
    .y      (r_y),
    .z      (r_z),
    .i      (r_count),
    .x_next (w_x_next),
    .y_next (w_y_next),
    .z_next (w_z_next)
  );

`ifdef CORDIC_VEC_GAIN_COMP_EN
  logic signed [IW-1:0] w_mag_gain;
  assign w_mag_gain = (r_x >>> GAIN_SH0) + (r_x >>> GAIN_SH1)
                    - (r_x >>> GAIN_SH2) - (r_x >>> GAIN_SH3);
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; every move waits for ce
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_ITER;
`ifdef CORDIC_VEC_GAIN_COMP_EN
      ST_ITER: if (ce && w_last) w_state_next = ST_GAIN;
`else
      ST_ITER: if (ce && w_last) w_state_next = ST_DONE;
`endif
      ST_GAIN: if (ce) w_state_next = ST_DONE;
      ST_DONE: if (ce && bus.out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Capture with quadrant pre-rotation, iterate, then latch the result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_count <= '0;
      r_zero  <= 1'b0;
      r_angle <= '0;
      r_mag   <= '0;
    end else if (ce) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_count <= '0;
            // The zero vector has no defined angle; report 0 rather than
            // the sum of the table that the y>=0 path would accumulate.
            r_zero  <= (w_x_in == '0) && (w_y_in == '0);
            if (w_x_in[IW-1] && !w_y_in[IW-1]) begin
              r_x <= w_y_in;
              r_y <= -w_x_in;
              r_z <= AW'(PI_2);
            end else if (w_x_in[IW-1]) begin
              r_x <= -w_y_in;
              r_y <= w_x_in;
              r_z <= -AW'(PI_2);
            end else begin
              r_x <= w_x_in;
              r_y <= w_y_in;
              r_z <= '0;
            end
          end
        end
        ST_ITER: begin
          r_x     <= w_x_next;
          r_y     <= w_y_next;
          r_z     <= w_z_next;
          r_count <= r_count + 1'b1;
`ifdef CORDIC_VEC_GAIN_COMP_EN
`else
          if (w_last) begin
            r_angle <= r_zero ? '0 : w_z_next;
            r_mag   <= w_x_next;
          end
`endif
        end
`ifdef CORDIC_VEC_GAIN_COMP_EN
        ST_GAIN: begin
          r_angle <= r_zero ? '0 : r_z;
          r_mag   <= w_mag_gain;
        end
`endif
        default: ;
      endcase
    end
  end

  // in_ready must read 0 while reset is asserted, even though the state is IDLE
  assign bus.in_ready  = (r_state == ST_IDLE) & reset_n;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.angle_out = r_angle;
  assign bus.mag_out   = r_mag;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// ============================================================================
// | Module      : tb_cordic_vectoring                                        |
// | Description : Self-checking bench for cordic_vectoring: directed corner  |
// |               vectors, handshake/stall/reset scenarios, an angle sweep   |
// |               and random vectors against a real-arithmetic model.        |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module tb_cordic_vectoring;

  localparam int N = 11;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int  LAT = N + 1;
  localparam real KG  = 1.0;
`else
  localparam int  LAT = N;
  localparam real KG  = 1.6467602581;
`endif
  localparam int ATOL = 4;
  localparam int MTOL = 6;

  logic clock = 1'b0;
  logic reset_n;
  logic ce;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  cordic_vectoring_if #(.W(12)) bus ();

  cordic_vectoring #(.W(12), .N(N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus)
  );

  // Model: exact atan2 in Q10 radians and magnitude scaled by the CORDIC gain
  function automatic int ref_angle(input int x, input int y);
    real a;
    a = $atan2(real'(y), real'(x)) * 1024.0;
    return $rtoi($floor(a + 0.5));
  endfunction

  function automatic int ref_mag(input int x, input int y);
    real m;
    m = $sqrt(real'(x * x + y * y)) * KG;
    return $rtoi($floor(m + 0.5));
  endfunction

  // +pi and -pi are the same direction; pick the expected branch nearest obs
  function automatic int wrap_exp(input int obs, input int exp_v);
    if (obs - exp_v > 3217) return exp_v + 6434;
    if (exp_v - obs > 3217) return exp_v - 6434;
    return exp_v;
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v, input int tol);
    n_checks++;
    if ((obs - exp_v > tol) || (exp_v - obs > tol)) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp_v, tol);
    end
  endtask

  // Present one vector, optionally drop ce for stall_len edges starting
  // stall_at edges after acceptance, and wait for the result
  task automatic run_vec(input int x, input int y, input int stall_at, input int stall_len,
                         output int lat, output int ang, output int mag);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    bus.x_in     = 12'(x);
    bus.y_in     = 12'(y);
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    check("busy_ready", int'(bus.in_ready), 0, 0);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      ce = !(stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
      @(posedge clock); #1;
      lat++;
    end
    ce  = 1'b1;
    ang = int'(bus.angle_out);
    mag = int'(bus.mag_out);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    check("valid_drop", int'(bus.out_valid), 0, 0);
    check("ready_back", int'(bus.in_ready), 1, 0);
  endtask

  task automatic run_and_check(input string tag, input int x, input int y);
    int lat, ang, mag;
    run_vec(x, y, 0, 0, lat, ang, mag);
    check({tag, "_lat"}, lat, LAT, 0);
    check({tag, "_ang"}, ang, wrap_exp(ang, ref_angle(x, y)), ATOL);
    check({tag, "_mag"}, mag, ref_mag(x, y), MTOL);
    take_result();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dx [6] = '{1024, 0, -1024, -724, -2048, 0};
    int dy [6] = '{0, 1024, 0, -724, 0, 0};
    int lat, ang, mag, lat2, ang2, mag2, x, y;

    reset_n       = 1'b0;
    ce            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", int'(bus.in_ready), 0, 0);
    check("rst_valid", int'(bus.out_valid), 0, 0);
    check("rst_angle", int'(bus.angle_out), 0, 0);
    check("rst_mag",   int'(bus.mag_out), 0, 0);
    reset_n = 1'b1;
    #1;
    check("rel_ready", int'(bus.in_ready), 1, 0);

    // Directed corner vectors, including x=-2.0 and the zero vector
    foreach (dx[k]) run_and_check($sformatf("dir%0d", k), dx[k], dy[k]);

    // Clock-enable stall mid-iteration: same result, three cycles later
    run_vec(700, -900, 0, 0, lat, ang, mag);
    check("ce_ref_lat", lat, LAT, 0);
    take_result();
    run_vec(700, -900, 4, 3, lat2, ang2, mag2);
    check("ce_lat", lat2, LAT + 3, 0);
    check("ce_ang", ang2, ang, 0);
    check("ce_mag", mag2, mag, 0);
    check("ce_ang_ref", ang2, ref_angle(700, -900), ATOL);
    take_result();

    // Back-pressure in DONE: stable outputs, stray in_valid ignored
    run_vec(500, 1500, 0, 0, lat, ang, mag);
    check("bp_ang_ref", ang, ref_angle(500, 1500), ATOL);
    check("bp_mag_ref", mag, ref_mag(500, 1500), MTOL);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0];
      bus.x_in     = 12'($urandom_range(0, 4095));
      bus.y_in     = 12'($urandom_range(0, 4095));
      @(posedge clock); #1;
      check("bp_valid", int'(bus.out_valid), 1, 0);
      check("bp_ready", int'(bus.in_ready), 0, 0);
      check("bp_ang",   int'(bus.angle_out), ang, 0);
      check("bp_mag",   int'(bus.mag_out), mag, 0);
    end
    bus.in_valid = 1'b0;
    // out_ready without ce must not release the result
    ce = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    check("ce0_hold", int'(bus.out_valid), 1, 0);
    ce = 1'b1;
    bus.out_ready = 1'b0;
    take_result();
    run_and_check("after_bp", -1500, 800);

    // Reset asserted during iteration 5 aborts at once
    run_vec(1200, 300, 0, 0, lat, ang, mag);
    take_result();
    bus.x_in = 12'(-900);
    bus.y_in = 12'(1100);
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_angle", int'(bus.angle_out), 0, 0);
    check("arst_mag",   int'(bus.mag_out), 0, 0);
    check("arst_ready", int'(bus.in_ready), 0, 0);
    check("arst_valid", int'(bus.out_valid), 0, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    check("arst_rel_ready", int'(bus.in_ready), 1, 0);
    repeat (LAT + 2) @(posedge clock);
    #1;
    check("arst_no_result", int'(bus.out_valid), 0, 0);

    // Round trip: unit vectors at known angles
    for (int a = -1608; a <= 1608; a += 67) begin
      x = $rtoi($floor($cos(real'(a) / 1024.0) * 1024.0 + 0.5));
      y = $rtoi($floor($sin(real'(a) / 1024.0) * 1024.0 + 0.5));
      run_vec(x, y, 0, 0, lat, ang, mag);
      check("rt_ang", ang, a, 6);
      check("rt_mag", mag, ref_mag(x, y), MTOL);
      take_result();
    end

    // Random vectors of useful magnitude across all quadrants
    for (int k = 0; k < 40; k++) begin
      do begin
        x = int'($urandom_range(0, 4095)) - 2048;
        y = int'($urandom_range(0, 4095)) - 2048;
      end while (x * x + y * y < 1024 * 1024);
      run_and_check("rnd", x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
